// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    SKIP
  } i2c_state_e;

  localparam int unsigned I2C_ADDR_W  = 7;
  localparam logic        I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus history flop; yields the clean level and its edges.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  // Reset to 1 so an idle (pulled-up) bus produces no edge on reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 1'b1;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_hist;
  assign fall  = ~r_sync & r_hist;

endmodule

// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, write strobes, read-byte fetch handshake.
import i2c_pkg::*;

module i2c_target #(
  parameter logic [4:0]  ADDR_HI = 5'b10100,
  parameter int unsigned TX_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       a0,
  input  logic       a1,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);

  logic w_scl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda;
  logic w_sda_rise;
  logic w_sda_fall;
  logic w_start;
  logic w_stop;
  logic [I2C_ADDR_W-1:0] w_own_addr;
  logic [7:0] w_shift_next;

  i2c_state_e r_state;
  logic [3:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_first;
  logic       r_rx_pend;
  logic       r_first_pend;
  logic       r_tx_req;
  logic       r_tx_pend;
  logic [7:0] r_lat_cnt;
  logic [7:0] r_tx_byte;
  logic       r_busy;

  i2c_sync_edge u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (scl_i),
    .level (w_scl),
    .rise  (w_scl_rise),
    .fall  (w_scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sda_i),
    .level (w_sda),
    .rise  (w_sda_rise),
    .fall  (w_sda_fall)
  );

  assign w_start      = w_sda_fall & w_scl;
  assign w_stop       = w_sda_rise & w_scl;
  assign w_own_addr   = {ADDR_HI, a1, a0};
  assign w_shift_next = {r_shift[6:0], w_sda};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_rw         <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_first   <= 1'b0;
      r_rx_pend    <= 1'b0;
      r_first_pend <= 1'b0;
      r_tx_req     <= 1'b0;
      r_tx_pend    <= 1'b0;
      r_lat_cnt    <= '0;
      r_tx_byte    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_tx_req   <= 1'b0;
      r_rx_valid <= 1'b0;

      // Completed write byte is published one cycle after the 8th rise.
      if (r_rx_pend) begin
        r_rx_pend    <= 1'b0;
        r_rx_data    <= r_shift;
        r_rx_valid   <= 1'b1;
        r_rx_first   <= r_first_pend;
        r_first_pend <= 1'b0;
      end

      // Read byte is captured in cycle tx_req + TX_LAT.
      if (r_tx_pend) begin
        if (r_lat_cnt == '0) begin
          r_tx_byte <= tx_data;
          r_tx_pend <= 1'b0;
        end else begin
          r_lat_cnt <= r_lat_cnt - 8'd1;
        end
      end

      if (w_stop) begin
        r_state  <= IDLE;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= ADDR;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= w_shift_next;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_rw <= w_sda;
                if (w_shift_next[7:1] != w_own_addr) begin
                  r_state <= SKIP;
                end
              end
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_state      <= ADDR_ACK;
              r_sda_oe     <= 1'b1;
              r_busy       <= 1'b1;
              r_first_pend <= (r_rw != I2C_RW_READ);
              if (r_rw == I2C_RW_READ) begin
                r_tx_req  <= 1'b1;
                r_tx_pend <= 1'b1;
                r_lat_cnt <= 8'(TX_LAT);
              end
            end
          end

          ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bitcnt <= '0;
              if (r_rw == I2C_RW_READ) begin
                r_state  <= RD_DATA;
                r_sda_oe <= ~r_tx_byte[7];
              end else begin
                r_state  <= WR_DATA;
                r_sda_oe <= 1'b0;
              end
            end
          end

          WR_DATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_shift_next;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_rx_pend <= 1'b1;
              end
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_state  <= WR_ACK;
              r_sda_oe <= 1'b1;
            end
          end

          WR_ACK: begin
            if (w_scl_fall) begin
              r_state  <= WR_DATA;
              r_sda_oe <= 1'b0;
              r_bitcnt <= '0;
            end
          end

          // Bit 7 is already on the bus at entry; each fall presents the next bit.
          RD_DATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_state  <= RD_ACK;
                r_sda_oe <= 1'b0;
              end else begin
                r_sda_oe <= ~r_tx_byte[3'd7 - r_bitcnt[2:0]];
              end
            end
          end

          // bitcnt 9 marks an ACKed byte awaiting the fall into the next one.
          RD_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_bitcnt  <= 4'd9;
                r_tx_req  <= 1'b1;
                r_tx_pend <= 1'b1;
                r_lat_cnt <= 8'(TX_LAT);
              end else begin
                r_state <= SKIP;
              end
            end else if (w_scl_fall && r_bitcnt == 4'd9) begin
              r_state  <= RD_DATA;
              r_bitcnt <= '0;
              r_sda_oe <= ~r_tx_byte[7];
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_first = r_rx_first;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;

endmodule
